// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder driving one adder1bit stage, LSB first, with valid/ready on both sides.
// Optional subtract path enabled by defining SERIAL_ADDER_SUB_EN.

module adder1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_s, fa_co;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_load     = b;
    assign c_load     = cin;
`endif

    adder1bit u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_s),
        .cout (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_load;
                    carry_d = c_load;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = {fa_s, acc_q[WIDTH-1:1]};
                carry_d = fa_co;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                // carry_q here is the carry into the MSB, hence the overflow term
                if (cnt_q == LAST) begin
                    sum_d   = {fa_s, acc_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around one instance of the existing 1-bit full adder (adder1bit), plus operand shift registers, a carry flip-flop and a result shift register.
- Sits directly around the 1-bit adder stage and drives it one bit per clock.
- Consumes operands via a valid/ready handshake and produces sum, carry-out and overflow via a valid/ready handshake.
- Intended as the low-area ALU add path for the lab CPU datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 2..64.

Ports:
- clk, input, 1, single system clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operands a, b, cin (and sub) are valid.
- in_ready, output, 1, block can accept operands (high only in IDLE).
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- cin, input, 1, carry-in.
- sub, input, 1, subtract request; only meaningful with SERIAL_ADDER_SUB_EN.
- busy, output, 1, high in RUN.
- out_valid, output, 1, result outputs valid (high only in DONE).
- out_ready, input, 1, downstream accepts result.
- sum, output, WIDTH, result.
- cout, output, 1, carry out of MSB.
- overflow, output, 1, signed overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State=IDLE; in_ready=1; busy=0; out_valid=0; sum=0; cout=0; overflow=0.
  - Bit counter, carry FF and operand registers cleared.
  - Asserting reset mid-RUN or in DONE aborts the operation and the result is lost.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a->A_sh, b->B_sh, cin->carry FF; clear counter and sum register; go to RUN.
  - in_valid=0: stay in IDLE.
- RUN:
  - in_ready=0, busy=1.
  - Each edge: adder1bit inputs are A_sh[0], B_sh[0], carry FF.
    - Its sum bit shifts into sum register MSB (sum shifts right).
    - Its carry-out loads the carry FF.
    - A_sh and B_sh shift right by one.
    - Counter increments.
  - Bits are processed LSB first; exactly WIDTH RUN cycles.
  - On the edge processing bit WIDTH-1:
    - capture cout = adder carry-out;
    - capture overflow = carry FF value (carry into MSB) XOR adder carry-out;
    - go to DONE.
  - in_valid is ignored during RUN.
- DONE:
  - out_valid=1; sum, cout and overflow are stable and held.
  - An edge with out_ready=1 goes to IDLE; out_valid drops on that edge.
  - out_ready=0 holds DONE indefinitely (backpressure); in_ready stays 0.
- Latency:
  - out_valid rises exactly WIDTH clocks after the accept edge.
  - Minimum accept-to-accept period is WIDTH+2 clocks (accept edge, WIDTH RUN edges, DONE handshake edge; next accept in IDLE).
- Output timing:
  - sum, cout and overflow change only on the edge that enters DONE, and on reset.
  - They retain their last values in IDLE and RUN.
- Arithmetic:
  - sum = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of the full sum.
  - Wrap-around: all-ones + 1 gives sum=0, cout=1.
- out_ready asserted outside DONE has no effect.
- Simultaneous in_valid and out_ready in DONE: only the result handshake occurs; input is not accepted until IDLE.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - When sub=1 at accept, B_sh loads ~b and the carry FF loads 1 (cin ignored), giving sum = a - b mod 2^WIDTH.
  - cout=1 means no borrow; overflow follows the same rule.
  - sub is sampled only at accept.
- Undefined:
  - sub is ignored entirely; behaviour is identical to sub=0.

Test Plan (bench overrides WIDTH=8):
- Reset: rst_n=0 then release -> in_ready=1, out_valid=0, busy=0, sum=0x00, cout=0, overflow=0.
- Basic add: a=0x05, b=0x03, cin=0, in_valid one cycle -> out_valid exactly 8 clocks later, sum=0x08, cout=0, overflow=0.
- Wrap and overflow:
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0.
  - a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, overflow=1.
- Carry-in: a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Backpressure and mid-operation reset:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid and sum stable, in_ready=0.
  - Pulse rst_n=0 at RUN bit 3 -> immediate IDLE, out_valid never asserted for that operation.
- Subtract (SERIAL_ADDER_SUB_EN defined):
  - a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0.
  - a=0x80, b=0x01, sub=1 -> sum=0x7F, overflow=1.
  - Macro undefined: same stimulus gives sum=0x0C / 0x81.
